vinsn_dispatcher: RTL and testbench

VINSN_DISPATCHER -- requirements
Module: vinsn_dispatcher

---
 rtl/core_pkg.sv | 84 ++++++++
 rtl/vinsn_dispatcher_if.sv | 32 +++
 rtl/vinsn_hazard_check.sv | 27 ++
 rtl/vinsn_dispatcher.sv | 98 +++++++++
 tb/tb_vinsn_dispatcher.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Core-wide vector types, sizes and decode helpers used by the dispatch path.
// Pure declarations; no timing or flow control lives here.
package core_pkg;

   localparam int unsigned NrVFU        = 3;
   localparam int unsigned InsnIDNum    = 8;
   localparam int unsigned VRFAddrWidth = 10;

   typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;
   typedef logic [4:0]                   vreg_t;
   typedef logic [15:0]                  vlen_t;
   typedef logic [VRFAddrWidth-1:0]      vaddr_t;

   typedef enum logic [2:0] {VADD, VSUB, VAND, VOR, VLE, VSE} vop_e;
   typedef enum logic [1:0] {EW8, EW16, EW32, EW64} vew_e;
   typedef enum logic [1:0] {VALU = 2'd0, VLU = 2'd1, VSU = 2'd2} vfu_e;

   // use_vs[0] qualifies vs1, use_vs[1] qualifies vs2
   typedef struct packed {
      vop_e        vop;
      vew_e        vew;
      vlen_t       vlB;
      vreg_t       vs1;
      vreg_t       vs2;
      vreg_t       vd;
      logic [1:0]  use_vs;
      logic        use_vd;
      logic [31:0] scalar_op;
      insn_id_t    insn_id;
      logic        flip_bit;
   } issue_req_t;

   typedef struct packed {
      vreg_t      vs1;
      vreg_t      vs2;
      vlen_t      vlB;
      logic [2:0] queue_req;
   } op_req_t;

   typedef struct packed {
      vop_e        vop;
      vew_e        vew;
      vlen_t       vlB;
      logic [1:0]  use_vs;
      logic [31:0] scalar_op;
      insn_id_t    insn_id;
      vreg_t       vd;
      vaddr_t      waddr;
   } vfu_req_t;

   typedef struct packed {
      vreg_t      vd;
      logic       use_vd;
      vreg_t      vs1;
      vreg_t      vs2;
      logic [1:0] use_vs;
   } insn_entry_t;

   // Queue 0/1 feed vs1/vs2 of arithmetic ops; queue 2 carries store data
   function automatic logic [2:0] GetOpQueue(vop_e vop, logic [1:0] use_vs);
      logic [2:0] q;
      case (vop)
         VLE:     q = 3'b000;
         VSE:     q = {use_vs[0], 2'b00};
         default: q = {1'b0, use_vs[1], use_vs[0]};
      endcase
      return q;
   endfunction

   function automatic vfu_e GetVFUByVOp(vop_e vop);
      vfu_e f;
      case (vop)
         VLE:     f = VLU;
         VSE:     f = VSU;
         default: f = VALU;
      endcase
      return f;
   endfunction

   function automatic vaddr_t GetVRFAddr(vreg_t vd);
      return {vd, 5'b00000};
   endfunction

endpackage

// File: rtl/vinsn_dispatcher_if.sv
// Issue, operand-request, VFU-request and completion signals of the dispatcher.
// slave = dispatcher side, master = issue/VFU environment side.
interface vinsn_dispatcher_if #(
   parameter int unsigned NrVFU     = core_pkg::NrVFU,
   parameter int unsigned InsnIDNum = core_pkg::InsnIDNum
) ();
   import core_pkg::*;

   logic                     issue_valid_i;
   issue_req_t               issue_req_i;
   logic                     issue_ready_o;
   logic                     op_req_valid_o;
   op_req_t                  op_req_o;
   logic                     op_req_ready_i;
   logic [NrVFU-1:0]         vfu_req_valid_o;
   vfu_req_t                 vfu_req_o;
   logic [NrVFU-1:0]         vfu_ready_i;
   logic [NrVFU-1:0]         vfu_done_i;
   insn_id_t [NrVFU-1:0]     vfu_done_id_i;
   logic [InsnIDNum-1:0]     insn_busy_o;

   modport slave (
      input  issue_valid_i, issue_req_i, op_req_ready_i, vfu_ready_i, vfu_done_i, vfu_done_id_i,
      output issue_ready_o, op_req_valid_o, op_req_o, vfu_req_valid_o, vfu_req_o, insn_busy_o
   );

   modport master (
      output issue_valid_i, issue_req_i, op_req_ready_i, vfu_ready_i, vfu_done_i, vfu_done_id_i,
      input  issue_ready_o, op_req_valid_o, op_req_o, vfu_req_valid_o, vfu_req_o, insn_busy_o
   );

endinterface

// File: rtl/vinsn_hazard_check.sv
// Flags RAW/WAW/WAR conflicts between a candidate instruction and every busy table entry.
// Purely combinational; no flow control.
module vinsn_hazard_check import core_pkg::*; #(
   parameter int unsigned InsnIDNum = core_pkg::InsnIDNum
) (
   input  logic [InsnIDNum-1:0]        busy,
   input  insn_entry_t [InsnIDNum-1:0] entries,
   input  insn_entry_t                 cand,
   output logic                        hazard
);

   function automatic logic conflicts(insn_entry_t e, insn_entry_t c);
      logic raw, waw, war;
      raw = e.use_vd && ((c.use_vs[0] && e.vd == c.vs1) || (c.use_vs[1] && e.vd == c.vs2));
      waw = e.use_vd && c.use_vd && (e.vd == c.vd);
      war = c.use_vd && ((e.use_vs[0] && e.vs1 == c.vd) || (e.use_vs[1] && e.vs2 == c.vd));
      return raw || waw || war;
   endfunction

   always_comb begin
      hazard = 1'b0;
      for (int unsigned i = 0; i < InsnIDNum; i++) begin
         if (busy[i] && conflicts(entries[i], cand)) hazard = 1'b1;
      end
   end

endmodule

// File: rtl/vinsn_dispatcher.sv
// Tracks in-flight vector instructions and dispatches hazard-free ones to operand fetch and a VFU.
// Outputs one cycle after accept; op and VFU handshakes drain independently, issue stalls until both clear.
module vinsn_dispatcher import core_pkg::*; #(
   parameter int unsigned NrVFU     = core_pkg::NrVFU,
   parameter int unsigned InsnIDNum = core_pkg::InsnIDNum
) (
   input logic               clk_i,
   input logic               rst_i,
   vinsn_dispatcher_if.slave dis
);

   logic [InsnIDNum-1:0]        busy_q, busy_d, done_mask;
   insn_entry_t [InsnIDNum-1:0] tbl_q;
   insn_entry_t                 cand;
   logic                        hazard;

   logic     op_pend_q, vfu_pend_q;
   op_req_t  op_req_q;
   vfu_req_t vfu_req_q;
   vfu_e     vfu_sel_q;

   logic vfu_rdy_sel, stage_free, accept;

   assign cand = '{vd:     dis.issue_req_i.vd,
                   use_vd: dis.issue_req_i.use_vd,
                   vs1:    dis.issue_req_i.vs1,
                   vs2:    dis.issue_req_i.vs2,
                   use_vs: dis.issue_req_i.use_vs};

   vinsn_hazard_check #(.InsnIDNum(InsnIDNum)) i_hazard (
      .busy    (busy_q),
      .entries (tbl_q),
      .cand    (cand),
      .hazard  (hazard)
   );

   assign vfu_rdy_sel = dis.vfu_ready_i[vfu_sel_q];
   assign stage_free  = (!op_pend_q || dis.op_req_ready_i) && (!vfu_pend_q || vfu_rdy_sel);

   // Busy and hazard look only at registered state: a done this cycle frees the id next cycle
   assign dis.issue_ready_o = !rst_i && !busy_q[dis.issue_req_i.insn_id] && !hazard && stage_free;
   assign accept            = dis.issue_valid_i && dis.issue_ready_o;

   always_comb begin
      done_mask = '0;
      for (int unsigned k = 0; k < NrVFU; k++) begin
         if (dis.vfu_done_i[k]) done_mask[dis.vfu_done_id_i[k]] = 1'b1;
      end
   end

   always_comb begin
      busy_d = busy_q & ~done_mask;
      if (accept) busy_d[dis.issue_req_i.insn_id] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q     <= '0;
         op_pend_q  <= 1'b0;
         vfu_pend_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (accept) begin
            op_pend_q  <= GetOpQueue(dis.issue_req_i.vop, dis.issue_req_i.use_vs) != 3'b000;
            vfu_pend_q <= 1'b1;
         end else begin
            if (dis.op_req_ready_i) op_pend_q  <= 1'b0;
            if (vfu_rdy_sel)        vfu_pend_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         tbl_q[dis.issue_req_i.insn_id] <= cand;
         op_req_q <= '{vs1:       dis.issue_req_i.vs1,
                       vs2:       dis.issue_req_i.vs2,
                       vlB:       dis.issue_req_i.vlB,
                       queue_req: GetOpQueue(dis.issue_req_i.vop, dis.issue_req_i.use_vs)};
         vfu_req_q <= '{vop:       dis.issue_req_i.vop,
                        vew:       dis.issue_req_i.vew,
                        vlB:       dis.issue_req_i.vlB,
                        use_vs:    dis.issue_req_i.use_vs,
                        scalar_op: dis.issue_req_i.scalar_op,
                        insn_id:   dis.issue_req_i.insn_id,
                        vd:        dis.issue_req_i.vd,
                        waddr:     GetVRFAddr(dis.issue_req_i.vd)};
         vfu_sel_q <= GetVFUByVOp(dis.issue_req_i.vop);
      end
   end

   assign dis.op_req_valid_o  = op_pend_q;
   assign dis.op_req_o        = op_req_q;
   assign dis.vfu_req_valid_o = vfu_pend_q ? (NrVFU'(1) << vfu_sel_q) : '0;
   assign dis.vfu_req_o       = vfu_req_q;
   assign dis.insn_busy_o     = busy_q;

endmodule

// File: tb/tb_vinsn_dispatcher.sv
// Directed scoreboard bench for vinsn_dispatcher.
module tb_vinsn_dispatcher;
   import core_pkg::*;

   typedef struct {
      logic [NrVFU-1:0] valid;
      vfu_req_t         req;
   } vfu_exp_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   op_req_t  op_q[$];
   vfu_exp_t vfu_q[$];
   vfu_exp_t mon_e;
   op_req_t  mon_o;

   vinsn_dispatcher_if #(.NrVFU(NrVFU), .InsnIDNum(InsnIDNum)) dis ();

   vinsn_dispatcher #(.NrVFU(NrVFU), .InsnIDNum(InsnIDNum)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .dis   (dis)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s", name, what);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic issue_req_t mk(vop_e vop, vreg_t vs1, vreg_t vs2, vreg_t vd,
                                     logic [1:0] use_vs, logic use_vd, insn_id_t id);
      issue_req_t r;
      r.vop       = vop;
      r.vew       = EW32;
      r.vlB       = 16'd64;
      r.vs1       = vs1;
      r.vs2       = vs2;
      r.vd        = vd;
      r.use_vs    = use_vs;
      r.use_vd    = use_vd;
      r.scalar_op = 32'h1000 + 32'(id);
      r.insn_id   = id;
      r.flip_bit  = id[0];
      return r;
   endfunction

   function automatic vfu_req_t mk_vfu(issue_req_t r, vaddr_t waddr);
      vfu_req_t v;
      v.vop       = r.vop;
      v.vew       = r.vew;
      v.vlB       = r.vlB;
      v.use_vs    = r.use_vs;
      v.scalar_op = r.scalar_op;
      v.insn_id   = r.insn_id;
      v.vd        = r.vd;
      v.waddr     = waddr;
      return v;
   endfunction

   task automatic expect_out(input issue_req_t r, input logic [2:0] q,
                             input logic [NrVFU-1:0] v, input vaddr_t waddr);
      vfu_exp_t e;
      op_req_t  o;
      if (q != 3'b000) begin
         o.vs1 = r.vs1; o.vs2 = r.vs2; o.vlB = r.vlB; o.queue_req = q;
         op_q.push_back(o);
      end
      e.valid = v;
      e.req   = mk_vfu(r, waddr);
      vfu_q.push_back(e);
   endtask

   task automatic issue(input issue_req_t r, input logic [2:0] q,
                        input logic [NrVFU-1:0] v, input vaddr_t waddr);
      int n;
      n = 0;
      dis.issue_valid_i = 1'b1;
      dis.issue_req_i   = r;
      @(negedge clk);
      while (!dis.issue_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!dis.issue_ready_o) fail("issue_timeout", "issue_ready_o stayed 0, required 1");
      else expect_out(r, q, v, waddr);
      tick();
      dis.issue_valid_i = 1'b0;
   endtask

   task automatic done(input vfu_e k, input insn_id_t id);
      dis.vfu_done_i[k]    = 1'b1;
      dis.vfu_done_id_i[k] = id;
      tick();
      dis.vfu_done_i = '0;
   endtask

   // Monitor: every completed handshake must match the head of its queue
   always @(negedge clk) begin
      if (!rst) begin
         if (dis.op_req_valid_o && dis.op_req_ready_i) begin
            if (op_q.size() == 0) fail("op_req_unexpected", "got handshake, required none");
            else begin
               mon_o = op_q.pop_front();
               check("op_req", 128'(dis.op_req_o), 128'(mon_o));
            end
         end
         if ((dis.vfu_req_valid_o & dis.vfu_ready_i) != '0) begin
            if (vfu_q.size() == 0) fail("vfu_req_unexpected", "got handshake, required none");
            else begin
               mon_e = vfu_q.pop_front();
               check("vfu_req_valid", 128'(dis.vfu_req_valid_o), 128'(mon_e.valid));
               check("vfu_req", 128'(dis.vfu_req_o), 128'(mon_e.req));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      issue_req_t r, r2;
      vfu_req_t   ev;

      dis.issue_valid_i  = 1'b0;
      dis.issue_req_i    = '0;
      dis.op_req_ready_i = 1'b1;
      dis.vfu_ready_i    = '1;
      dis.vfu_done_i     = '0;
      dis.vfu_done_id_i  = '0;
      rst = 1'b1;

      // Reset state
      tick(); tick();
      @(negedge clk);
      check("rst_busy",        128'(dis.insn_busy_o),     128'(8'h00));
      check("rst_issue_ready", 128'(dis.issue_ready_o),   128'(1'b0));
      check("rst_op_valid",    128'(dis.op_req_valid_o),  128'(1'b0));
      check("rst_vfu_valid",   128'(dis.vfu_req_valid_o), 128'(3'b000));
      rst = 1'b0;
      tick();

      // Basic VADD v1,v2 -> v3, id 0
      r = mk(VADD, 5'd1, 5'd2, 5'd3, 2'b11, 1'b1, 3'd0);
      issue(r, 3'b011, 3'b001, 10'd96);
      @(negedge clk);
      check("vadd_busy",      128'(dis.insn_busy_o),        128'(8'h01));
      check("vadd_op_valid",  128'(dis.op_req_valid_o),     128'(1'b1));
      check("vadd_vfu_valid", 128'(dis.vfu_req_valid_o),    128'(3'b001));
      check("vadd_queue_req", 128'(dis.op_req_o.queue_req), 128'(3'b011));
      check("vadd_waddr",     128'(dis.vfu_req_o.waddr),    128'(10'd96));
      tick();
      done(VALU, 3'd0);
      @(negedge clk);
      check("vadd_busy_clr", 128'(dis.insn_busy_o), 128'(8'h00));
      tick();

      // RAW: VSUB v3,v4 -> v5 waits for VADD completion
      r = mk(VADD, 5'd1, 5'd2, 5'd3, 2'b11, 1'b1, 3'd0);
      issue(r, 3'b011, 3'b001, 10'd96);
      r2 = mk(VSUB, 5'd3, 5'd4, 5'd5, 2'b11, 1'b1, 3'd1);
      dis.issue_valid_i = 1'b1;
      dis.issue_req_i   = r2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("raw_stall", 128'(dis.issue_ready_o), 128'(1'b0));
      end
      tick();
      dis.vfu_done_i[VALU]    = 1'b1;
      dis.vfu_done_id_i[VALU] = 3'd0;
      @(negedge clk);
      check("raw_no_bypass", 128'(dis.issue_ready_o), 128'(1'b0));
      tick();
      dis.vfu_done_i = '0;
      @(negedge clk);
      check("raw_ready_after_done", 128'(dis.issue_ready_o), 128'(1'b1));
      expect_out(r2, 3'b011, 3'b001, 10'd160);
      tick();
      dis.issue_valid_i = 1'b0;
      done(VALU, 3'd1);

      // VLE v8 id2: no op_req, VLU; VSE reading v8 waits for VLU done
      r = mk(VLE, 5'd0, 5'd0, 5'd8, 2'b00, 1'b1, 3'd2);
      issue(r, 3'b000, 3'b010, 10'd256);
      @(negedge clk);
      check("vle_no_op_req",   128'(dis.op_req_valid_o),  128'(1'b0));
      check("vle_vfu_valid",   128'(dis.vfu_req_valid_o), 128'(3'b010));
      r2 = mk(VSE, 5'd8, 5'd0, 5'd0, 2'b01, 1'b0, 3'd3);
      tick();
      dis.issue_valid_i = 1'b1;
      dis.issue_req_i   = r2;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("vse_stall", 128'(dis.issue_ready_o), 128'(1'b0));
      end
      tick();
      dis.vfu_done_i[VLU]    = 1'b1;
      dis.vfu_done_id_i[VLU] = 3'd2;
      tick();
      dis.vfu_done_i = '0;
      @(negedge clk);
      check("vse_ready_after_done", 128'(dis.issue_ready_o), 128'(1'b1));
      expect_out(r2, 3'b100, 3'b100, 10'd0);
      tick();
      dis.issue_valid_i = 1'b0;
      done(VSU, 3'd3);

      // VFU backpressure: op drains at once, VFU request held
      dis.vfu_ready_i = '0;
      r = mk(VADD, 5'd6, 5'd7, 5'd9, 2'b11, 1'b1, 3'd4);
      issue(r, 3'b011, 3'b001, 10'd288);
      ev = mk_vfu(r, 10'd288);
      r2 = mk(VOR, 5'd10, 5'd11, 5'd12, 2'b11, 1'b1, 3'd5);
      dis.issue_valid_i = 1'b1;
      dis.issue_req_i   = r2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_vfu_valid", 128'(dis.vfu_req_valid_o), 128'(3'b001));
         check("hold_vfu_req",   128'(dis.vfu_req_o),       128'(ev));
         check("hold_no_accept", 128'(dis.issue_ready_o),   128'(1'b0));
         check("hold_op_valid",  128'(dis.op_req_valid_o),  128'(i == 0));
      end
      tick();
      dis.vfu_ready_i = '1;
      issue(r2, 3'b011, 3'b001, 10'd384);
      @(negedge clk);
      check("hold_busy_after", 128'(dis.insn_busy_o), 128'(8'h30));

      // Same-id stall, then simultaneous done(5) + accept(6)
      done(VALU, 3'd4);
      @(negedge clk);
      check("id5_busy", 128'(dis.insn_busy_o), 128'(8'h20));
      r = mk(VAND, 5'd13, 5'd14, 5'd15, 2'b11, 1'b1, 3'd5);
      dis.issue_valid_i = 1'b1;
      dis.issue_req_i   = r;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("id5_stall", 128'(dis.issue_ready_o), 128'(1'b0));
      end
      dis.vfu_done_i[VALU]    = 1'b1;
      dis.vfu_done_id_i[VALU] = 3'd5;
      tick();
      dis.vfu_done_i = '0;
      @(negedge clk);
      check("id5_ready", 128'(dis.issue_ready_o), 128'(1'b1));
      expect_out(r, 3'b011, 3'b001, 10'd480);
      tick();
      dis.issue_valid_i = 1'b0;
      r2 = mk(VOR, 5'd16, 5'd17, 5'd18, 2'b11, 1'b1, 3'd6);
      dis.issue_valid_i       = 1'b1;
      dis.issue_req_i         = r2;
      dis.vfu_done_i[VALU]    = 1'b1;
      dis.vfu_done_id_i[VALU] = 3'd5;
      @(negedge clk);
      check("swap_busy_before", 128'(dis.insn_busy_o),   128'(8'h20));
      check("swap_ready",       128'(dis.issue_ready_o), 128'(1'b1));
      expect_out(r2, 3'b011, 3'b001, 10'd576);
      tick();
      dis.issue_valid_i = 1'b0;
      dis.vfu_done_i    = '0;
      @(negedge clk);
      check("swap_busy_after", 128'(dis.insn_busy_o), 128'(8'h40));
      done(VALU, 3'd6);

      // Reset mid-handshake
      dis.op_req_ready_i = 1'b0;
      dis.vfu_ready_i    = '0;
      r = mk(VADD, 5'd20, 5'd21, 5'd22, 2'b11, 1'b1, 3'd7);
      issue(r, 3'b011, 3'b001, 10'd704);
      @(negedge clk);
      check("prerst_vfu_valid", 128'(dis.vfu_req_valid_o), 128'(3'b001));
      check("prerst_busy",      128'(dis.insn_busy_o),     128'(8'h80));
      rst = 1'b1;
      #1;
      check("rst_gates_ready", 128'(dis.issue_ready_o), 128'(1'b0));
      op_q.delete();
      vfu_q.delete();
      @(negedge clk);
      check("postrst_op_valid",  128'(dis.op_req_valid_o),  128'(1'b0));
      check("postrst_vfu_valid", 128'(dis.vfu_req_valid_o), 128'(3'b000));
      check("postrst_busy",      128'(dis.insn_busy_o),     128'(8'h00));
      rst = 1'b0;
      dis.op_req_ready_i = 1'b1;
      dis.vfu_ready_i    = '1;
      tick();

      // Recovery after reset
      r = mk(VADD, 5'd1, 5'd2, 5'd3, 2'b11, 1'b1, 3'd0);
      issue(r, 3'b011, 3'b001, 10'd96);
      @(negedge clk);
      check("recover_busy", 128'(dis.insn_busy_o), 128'(8'h01));
      tick(); tick();
      check("leftover_op",  128'(op_q.size()),  128'(0));
      check("leftover_vfu", 128'(vfu_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
